// File: rtl/mem_bus_pkg.sv
// Shared types for the IF/MEM memory port arbiter: FSM states, owner encoding
// and the default timeout bound.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    localparam int MAX_WAIT_DEF = 255;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// SRAM-like memory port bundle; the arbiter is the master, the memory the slave.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic              mem_wr;
    logic [3:0]        mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_addr_ok;
    logic              mem_data_ok;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_wr, mem_wen, mem_addr, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata
    );

    modport slave (
        input  mem_req, mem_wr, mem_wen, mem_addr, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );
endinterface

// File: rtl/mem_arb_wait_cnt.sv
// Transaction timeout counter: cleared at grant, counts busy cycles and flags
// expiry during the MAX_WAIT-th busy cycle.
module mem_arb_wait_cnt #(
    parameter int MAX_WAIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    logic [CW-1:0] cnt_r;

    // Busy-cycle counter, clear has priority over count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (clr) begin
            cnt_r <= {CW{1'b0}};
        end else if (en) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expire = en && (cnt_r == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one SRAM-like port between instruction fetch and data access.
// Optional build macro MEM_ARB_RR_EN selects round-robin instead of data-first.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_done,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [3:0]        data_wen,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_done,
    output logic              bus_err,
    mem_bus_arbiter_if.master mem
);
    state_t            state_r, state_s;
    owner_t            owner_r, owner_s;
    logic              grant_s, complete_s, abort_s, finish_s;
    logic              inst_elig_s, data_elig_s, expire_s;
    owner_t            both_pick_s;
    logic              mem_req_r, mem_wr_r;
    logic [3:0]        mem_wen_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic [DATA_W-1:0] inst_rdata_r, data_rdata_r;
    logic              inst_done_r, data_done_r, bus_err_r;

`ifdef MEM_ARB_RR_EN
    owner_t last_owner_r;

    // Remembers who was granted last so a tie goes to the other side.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner_r <= OWN_INST;
        end else if (grant_s) begin
            last_owner_r <= owner_s;
        end else begin
            last_owner_r <= last_owner_r;
        end
    end

    assign both_pick_s = (last_owner_r == OWN_INST) ? OWN_DATA : OWN_INST;
`else
    assign both_pick_s = OWN_DATA;
`endif

    mem_arb_wait_cnt #(.MAX_WAIT(MAX_WAIT)) u_wait_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (grant_s),
        .en     ((state_r == ADDR) || (state_r == DATA)),
        .expire (expire_s)
    );

    // A requester still holding req in its done cycle must not be re-granted.
    assign inst_elig_s = inst_req && !inst_done_r;
    assign data_elig_s = data_req && !data_done_r;
    assign finish_s    = complete_s || abort_s;

    // Next-state, grant and completion decode.
    always_comb begin
        state_s    = state_r;
        owner_s    = owner_r;
        grant_s    = 1'b0;
        complete_s = 1'b0;
        abort_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (inst_elig_s && data_elig_s) begin
                    grant_s = 1'b1;
                    owner_s = both_pick_s;
                end else if (data_elig_s) begin
                    grant_s = 1'b1;
                    owner_s = OWN_DATA;
                end else if (inst_elig_s) begin
                    grant_s = 1'b1;
                    owner_s = OWN_INST;
                end else begin
                    grant_s = 1'b0;
                end
                state_s = grant_s ? ADDR : IDLE;
            end
            ADDR: begin
                if (mem.mem_addr_ok && mem.mem_data_ok) begin
                    complete_s = 1'b1;
                    state_s    = IDLE;
                end else if (expire_s) begin
                    abort_s = 1'b1;
                    state_s = IDLE;
                end else if (mem.mem_addr_ok) begin
                    state_s = DATA;
                end else begin
                    state_s = ADDR;
                end
            end
            DATA: begin
                if (mem.mem_data_ok) begin
                    complete_s = 1'b1;
                    state_s    = IDLE;
                end else if (expire_s) begin
                    abort_s = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = DATA;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, request fields toward memory and per-requester results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            owner_r      <= OWN_INST;
            mem_req_r    <= 1'b0;
            mem_wr_r     <= 1'b0;
            mem_wen_r    <= 4'b0000;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_wdata_r  <= {DATA_W{1'b0}};
            inst_rdata_r <= {DATA_W{1'b0}};
            data_rdata_r <= {DATA_W{1'b0}};
            inst_done_r  <= 1'b0;
            data_done_r  <= 1'b0;
            bus_err_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            owner_r   <= owner_s;
            mem_req_r <= (state_s == ADDR);
            if (grant_s && (owner_s == OWN_DATA)) begin
                mem_wr_r    <= data_wr;
                mem_wen_r   <= data_wr ? data_wen : 4'b0000;
                mem_addr_r  <= data_addr;
                mem_wdata_r <= data_wdata;
            end else if (grant_s) begin
                mem_wr_r    <= 1'b0;
                mem_wen_r   <= 4'b0000;
                mem_addr_r  <= inst_addr;
                mem_wdata_r <= {DATA_W{1'b0}};
            end else begin
                mem_wr_r    <= mem_wr_r;
                mem_wen_r   <= mem_wen_r;
                mem_addr_r  <= mem_addr_r;
                mem_wdata_r <= mem_wdata_r;
            end
            inst_done_r <= finish_s && (owner_r == OWN_INST);
            data_done_r <= finish_s && (owner_r == OWN_DATA);
            // A timeout returns zero data rather than whatever the bus holds.
            if (finish_s && (owner_r == OWN_INST)) begin
                inst_rdata_r <= complete_s ? mem.mem_rdata : {DATA_W{1'b0}};
            end else if (finish_s) begin
                data_rdata_r <= complete_s ? mem.mem_rdata : {DATA_W{1'b0}};
            end else begin
                inst_rdata_r <= inst_rdata_r;
                data_rdata_r <= data_rdata_r;
            end
            bus_err_r <= bus_err_r || abort_s;
        end
    end

    assign mem.mem_req   = mem_req_r;
    assign mem.mem_wr    = mem_wr_r;
    assign mem.mem_wen   = mem_wen_r;
    assign mem.mem_addr  = mem_addr_r;
    assign mem.mem_wdata = mem_wdata_r;
    assign inst_rdata    = inst_rdata_r;
    assign inst_done     = inst_done_r;
    assign data_rdata    = data_rdata_r;
    assign data_done     = data_done_r;
    assign bus_err       = bus_err_r;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (timeout bound set to 8).
module tb_mem_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_done;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_done;
    logic        bus_err;

    int checks = 0;
    int errors = 0;
    int rc = 0;
    int ic = 0;
    int dc = 0;
    logic [31:0] exp_a;
    logic [31:0] exp_b;

    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_req   (inst_req),
        .inst_addr  (inst_addr),
        .inst_rdata (inst_rdata),
        .inst_done  (inst_done),
        .data_req   (data_req),
        .data_wr    (data_wr),
        .data_wen   (data_wen),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_rdata (data_rdata),
        .data_done  (data_done),
        .bus_err    (bus_err),
        .mem        (mem_if.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (mem_if.mem_req) rc++;
        if (inst_done) ic++;
        if (data_done) dc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; inst_req = 1'b0; inst_addr = 32'h0; data_req = 1'b0; data_wr = 1'b0;
        data_wen = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
        mem_if.mem_addr_ok = 1'b0; mem_if.mem_data_ok = 1'b0; mem_if.mem_rdata = 32'h0;
        tick(); tick();
        chk("rst_req", {31'd0, mem_if.mem_req}, 32'd0);
        chk("rst_addr", mem_if.mem_addr, 32'd0);
        chk("rst_done", {30'd0, inst_done, data_done}, 32'd0);
        chk("rst_err", {31'd0, bus_err}, 32'd0);
        rst = 1'b0;

        // 1: single inst read, addr_ok on 2nd ADDR cycle, data_ok on 3rd DATA cycle
        rc = 0; ic = 0;
        inst_req = 1'b1; inst_addr = 32'h0040_0000;
        tick();
        chk("t1_req", {31'd0, mem_if.mem_req}, 32'd1);
        chk("t1_addr", mem_if.mem_addr, 32'h0040_0000);
        chk("t1_wrwen", {27'd0, mem_if.mem_wr, mem_if.mem_wen}, 32'd0);
        tick();
        mem_if.mem_addr_ok = 1'b1;
        tick();
        mem_if.mem_addr_ok = 1'b0;
        chk("t1_data_req", {31'd0, mem_if.mem_req}, 32'd0);
        tick(); tick();
        mem_if.mem_data_ok = 1'b1; mem_if.mem_rdata = 32'h2402_0001;
        tick();
        mem_if.mem_data_ok = 1'b0; mem_if.mem_rdata = 32'h0;
        chk("t1_done", {31'd0, inst_done}, 32'd1);
        chk("t1_rdata", inst_rdata, 32'h2402_0001);
        inst_req = 1'b0;
        tick();
        chk("t1_done_off", {31'd0, inst_done}, 32'd0);
        chk("t1_rdata_hold", inst_rdata, 32'h2402_0001);
        chk("t1_req_cycles", rc, 32'd2);
        chk("t1_done_cnt", ic, 32'd1);

        // 2: simultaneous requests, data store first, inst in the data_done cycle
        inst_req = 1'b1; inst_addr = 32'h0040_0004;
        data_req = 1'b1; data_wr = 1'b1; data_wen = 4'b0011;
        data_addr = 32'h8000_0010; data_wdata = 32'hDEAD_BEEF;
        tick();
        chk("t2_addr", mem_if.mem_addr, 32'h8000_0010);
        chk("t2_wrwen", {27'd0, mem_if.mem_wr, mem_if.mem_wen}, 32'h13);
        chk("t2_wdata", mem_if.mem_wdata, 32'hDEAD_BEEF);
        mem_if.mem_addr_ok = 1'b1;
        tick();
        mem_if.mem_addr_ok = 1'b0; mem_if.mem_data_ok = 1'b1; mem_if.mem_rdata = 32'h1111_1111;
        tick();
        mem_if.mem_data_ok = 1'b0;
        chk("t2_ddone", {30'd0, data_done, inst_done}, 32'd2);
        chk("t2_drdata", data_rdata, 32'h1111_1111);
        data_req = 1'b0; data_wr = 1'b0;
        tick();
        chk("t2_inst_req", {31'd0, mem_if.mem_req}, 32'd1);
        chk("t2_inst_addr", mem_if.mem_addr, 32'h0040_0004);
        chk("t2_inst_wrwen", {27'd0, mem_if.mem_wr, mem_if.mem_wen}, 32'd0);
        mem_if.mem_addr_ok = 1'b1; mem_if.mem_data_ok = 1'b1; mem_if.mem_rdata = 32'h2222_2222;
        tick();
        mem_if.mem_addr_ok = 1'b0; mem_if.mem_data_ok = 1'b0;
        chk("t2_idone", {31'd0, inst_done}, 32'd1);
        chk("t2_irdata", inst_rdata, 32'h2222_2222);
        inst_req = 1'b0;
        tick();

        // 3: zero-wait memory with inst_req held; no re-grant in the done cycle
        inst_req = 1'b1; inst_addr = 32'h0040_0008;
        mem_if.mem_addr_ok = 1'b1; mem_if.mem_data_ok = 1'b1; mem_if.mem_rdata = 32'h3333_3333;
        tick();
        chk("t3_req", {31'd0, mem_if.mem_req}, 32'd1);
        tick();
        chk("t3_done", {31'd0, inst_done}, 32'd1);
        chk("t3_rdata", inst_rdata, 32'h3333_3333);
        inst_addr = 32'h0040_000C;
        tick();
        chk("t3_no_double", {31'd0, mem_if.mem_req}, 32'd0);
        tick();
        chk("t3_regrant", {31'd0, mem_if.mem_req}, 32'd1);
        chk("t3_addr2", mem_if.mem_addr, 32'h0040_000C);
        tick();
        chk("t3_done2", {31'd0, inst_done}, 32'd1);
        inst_req = 1'b0; mem_if.mem_addr_ok = 1'b0; mem_if.mem_data_ok = 1'b0;
        tick();

        // 4: addr_ok never arrives on a load, abort after 8 busy cycles
        rc = 0; dc = 0;
        data_req = 1'b1; data_wr = 1'b0; data_wen = 4'hF; data_addr = 32'h8000_0020;
        mem_if.mem_rdata = 32'h5555_5555;
        tick();
        chk("t4_wrwen", {27'd0, mem_if.mem_wr, mem_if.mem_wen}, 32'd0);
        repeat (7) tick();
        chk("t4_pre_done", {30'd0, data_done, bus_err}, 32'd0);
        tick();
        chk("t4_done", {31'd0, data_done}, 32'd1);
        chk("t4_rdata", data_rdata, 32'd0);
        chk("t4_err", {31'd0, bus_err}, 32'd1);
        chk("t4_req_cycles", rc, 32'd8);
        data_req = 1'b0;
        tick();
        chk("t4_err_sticky", {31'd0, bus_err}, 32'd1);
        chk("t4_done_cnt", dc, 32'd1);

        // 5: reset while in DATA abandons the transaction
        ic = 0;
        inst_req = 1'b1; inst_addr = 32'h0040_0010;
        tick();
        mem_if.mem_addr_ok = 1'b1;
        tick();
        mem_if.mem_addr_ok = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; inst_req = 1'b0;
        chk("t5_req", {31'd0, mem_if.mem_req}, 32'd0);
        chk("t5_outs", {29'd0, inst_done, data_done, bus_err}, 32'd0);
        chk("t5_addr", mem_if.mem_addr, 32'd0);
        chk("t5_irdata", inst_rdata, 32'd0);
        tick();
        chk("t5_no_done", ic, 32'd0);

        // 6: data served last, then both requests held: priority and alternation
        mem_if.mem_addr_ok = 1'b1; mem_if.mem_data_ok = 1'b1; mem_if.mem_rdata = 32'h6666_6666;
        data_req = 1'b1; data_addr = 32'h8000_0030;
        tick(); tick();
        chk("t6_ddone", {31'd0, data_done}, 32'd1);
        chk("t6_drdata", data_rdata, 32'h6666_6666);
        data_req = 1'b0;
        tick();
        inst_req = 1'b1; inst_addr = 32'h0040_0014;
        data_req = 1'b1; data_addr = 32'h8000_0034;
`ifdef MEM_ARB_RR_EN
        exp_a = 32'h0040_0014; exp_b = 32'h8000_0034;
`else
        exp_a = 32'h8000_0034; exp_b = 32'h0040_0014;
`endif
        tick();
        chk("t6_grant1", mem_if.mem_addr, exp_a);
        tick(); tick();
        chk("t6_grant2", mem_if.mem_addr, exp_b);
        tick(); tick();
        chk("t6_grant3", mem_if.mem_addr, exp_a);
        tick();
        inst_req = 1'b0; data_req = 1'b0;
        mem_if.mem_addr_ok = 1'b0; mem_if.mem_data_ok = 1'b0;
        tick(); tick();
        chk("t6_idle", {31'd0, mem_if.mem_req}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
